pkt_slip_enc: RTL and testbench

PKT_SLIP_ENC -- requirements
Module: pkt_slip_enc

---
 rtl/pkt_slip_enc_pkg.sv | 16 +
 rtl/pkt_slip_enc.sv | 121 ++++++++++++
 tb/tb_pkt_slip_enc.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_slip_enc_pkg.sv
// Shared SLIP byte constants and encoder state encoding.
package pkt_slip_enc_pkg;

  localparam logic [7:0] SLIP_END     = 8'hC0;
  localparam logic [7:0] SLIP_ESC     = 8'hDB;
  localparam logic [7:0] SLIP_ESC_END = 8'hDC;
  localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ESC2 = 2'd2,
    TAIL = 2'd3
  } state_t;

endpackage

// File: rtl/pkt_slip_enc.sv
// SLIP frame encoder: pulls packet bytes from a FIFO read port and emits an
// escaped, END-delimited byte stream through a registered valid/ready output.
module pkt_slip_enc
  import pkt_slip_enc_pkg::*;
#(
  parameter bit LEADING_END = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_empty,
  output logic       in_ren,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  state_t     state, nxt;
  logic [7:0] esc_byte, esc_byte_nxt;
  logic       esc_last, esc_last_nxt;
  logic       tail_pend;
  logic       load;
  logic       take_byte;
  logic       ld_valid;
  logic [7:0] ld_data;

  // Output register may take a new value when empty or being drained.
  assign load = !out_valid || out_ready;

  // Next state, output-register load value and FIFO pop.
  always_comb begin
    nxt          = state;
    ld_valid     = 1'b0;
    ld_data      = out_data;
    in_ren       = 1'b0;
    esc_byte_nxt = esc_byte;
    esc_last_nxt = esc_last;
    take_byte    = 1'b0;

    case (state)
      IDLE: begin
        if (load && !in_empty) begin
          if (LEADING_END) begin
            ld_valid = 1'b1;
            ld_data  = SLIP_END;
            nxt      = DATA;
          end else begin
            take_byte = 1'b1;
          end
        end
      end
      DATA: begin
        if (load && !in_empty) take_byte = 1'b1;
      end
      // Second half of an escape pair needs no input, so it never stalls on
      // an empty FIFO and the pair stays contiguous.
      ESC2: begin
        if (load) begin
          ld_valid = 1'b1;
          ld_data  = esc_byte;
          nxt      = esc_last ? TAIL : DATA;
        end
      end
      TAIL: begin
        if (load) begin
          ld_valid = 1'b1;
          ld_data  = SLIP_END;
          nxt      = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase

    // Consume one source byte, escaping the two reserved values.
    if (take_byte) begin
      in_ren   = 1'b1;
      ld_valid = 1'b1;
      if (in_data == SLIP_END) begin
        ld_data      = SLIP_ESC;
        esc_byte_nxt = SLIP_ESC_END;
        esc_last_nxt = in_last;
        nxt          = ESC2;
      end else if (in_data == SLIP_ESC) begin
        ld_data      = SLIP_ESC;
        esc_byte_nxt = SLIP_ESC_ESC;
        esc_last_nxt = in_last;
        nxt          = ESC2;
      end else begin
        ld_data = in_data;
        nxt     = in_last ? TAIL : DATA;
      end
    end
  end

  // State, escape memory and output register; tail_pend marks the closing END
  // still waiting in the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      esc_byte  <= 8'h00;
      esc_last  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      tail_pend <= 1'b0;
    end else begin
      state    <= nxt;
      esc_byte <= esc_byte_nxt;
      esc_last <= esc_last_nxt;
      if (load) begin
        out_valid <= ld_valid;
        out_data  <= ld_data;
        tail_pend <= ld_valid && (state == TAIL);
      end
    end
  end

  assign busy = (state != IDLE) || tail_pend;

endmodule

// File: tb/tb_pkt_slip_enc.sv
// Scoreboard bench: stimulus pushes expected SLIP bytes, monitors pop and
// compare on every accepted output byte. dut1 uses LEADING_END=1, dut0 uses 0.
module tb_pkt_slip_enc;
  import pkt_slip_enc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- dut1 (LEADING_END=1) with FIFO model ----------------
  logic [7:0] mem1 [64];
  logic       lst1 [64];
  int         wr1 = 0;
  int         rd1 = 0;
  logic       hold1 = 1'b0;
  logic [7:0] in_data1, out_data1;
  logic       in_last1, in_empty1, in_ren1, out_valid1, busy1;
  logic       out_ready1 = 1'b1;
  logic [7:0] exp1 [$];

  assign in_data1  = mem1[rd1 % 64];
  assign in_last1  = lst1[rd1 % 64];
  assign in_empty1 = (rd1 == wr1) || hold1;

  always @(posedge clk or posedge rst)
    if (rst) rd1 <= wr1;
    else if (in_ren1) rd1 <= rd1 + 1;

  pkt_slip_enc #(.LEADING_END(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .in_data(in_data1), .in_last(in_last1), .in_empty(in_empty1), .in_ren(in_ren1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1), .busy(busy1)
  );

  // ---------------- dut0 (LEADING_END=0) with FIFO model ----------------
  logic [7:0] mem0 [64];
  logic       lst0 [64];
  int         wr0 = 0;
  int         rd0 = 0;
  logic [7:0] in_data0, out_data0;
  logic       in_last0, in_empty0, in_ren0, out_valid0, busy0;
  logic       out_ready0 = 1'b1;
  logic [7:0] exp0 [$];

  assign in_data0  = mem0[rd0 % 64];
  assign in_last0  = lst0[rd0 % 64];
  assign in_empty0 = (rd0 == wr0);

  always @(posedge clk or posedge rst)
    if (rst) rd0 <= wr0;
    else if (in_ren0) rd0 <= rd0 + 1;

  pkt_slip_enc #(.LEADING_END(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .in_data(in_data0), .in_last(in_last0), .in_empty(in_empty0), .in_ren(in_ren0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0), .busy(busy0)
  );

  // ---------------- monitors ----------------
  logic       stall1 = 1'b0;
  logic [7:0] stall_d1 = 8'h00;
  int         nacc1 = 0, first1 = 0, lastc1 = 0;

  always @(negedge clk) begin
    if (rst) stall1 = 1'b0;
    else begin
      if (in_ren1 && in_empty1) check("ren_while_empty1", 1, 0);
      if (stall1) check("stall_hold1", {23'd0, out_valid1, out_data1}, {23'd0, 1'b1, stall_d1});
      stall1   = out_valid1 && !out_ready1;
      stall_d1 = out_data1;
      if (out_valid1 && out_ready1) begin
        if (exp1.size() == 0) check("extra_byte1", {24'd0, out_data1}, 32'hFFFF_FFFF);
        else check("out1", {24'd0, out_data1}, {24'd0, exp1.pop_front()});
        if (nacc1 == 0) first1 = cyc;
        lastc1 = cyc;
        nacc1++;
      end
    end
  end

  int nacc0 = 0, first0 = 0, lastc0 = 0, blow0 = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (nacc0 > 0 && exp0.size() > 0 && !busy0) blow0++;
      if (out_valid0 && out_ready0) begin
        if (exp0.size() == 0) check("extra_byte0", {24'd0, out_data0}, 32'hFFFF_FFFF);
        else check("out0", {24'd0, out_data0}, {24'd0, exp0.pop_front()});
        if (nacc0 == 0) first0 = cyc;
        lastc0 = cyc;
        nacc0++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push1(input logic [7:0] d, input logic l);
    mem1[wr1 % 64] = d; lst1[wr1 % 64] = l; wr1++;
  endtask

  task automatic push0(input logic [7:0] d, input logic l);
    mem0[wr0 % 64] = d; lst0[wr0 % 64] = l; wr0++;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain1(input int budget, input bit toggle);
    int n = 0;
    while (exp1.size() > 0 && n < budget) begin
      step();
      if (toggle) out_ready1 = ~out_ready1;
      n++;
    end
    if (exp1.size() > 0) check("drain1_timeout", exp1.size(), 0);
    out_ready1 = 1'b1;
    repeat (2) step();
  endtask

  task automatic drain0(input int budget);
    int n = 0;
    while (exp0.size() > 0 && n < budget) begin
      step();
      n++;
    end
    if (exp0.size() > 0) check("drain0_timeout", exp0.size(), 0);
    repeat (2) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int start, ps, n;
    repeat (2) step();
    // Reset state
    check("rst_valid1", out_valid1, 0);
    check("rst_data1",  out_data1, 0);
    check("rst_busy1",  busy1, 0);
    check("rst_ren1",   in_ren1, 0);
    check("rst_state1", dut1.state, IDLE);
    check("rst_valid0", out_valid0, 0);
    check("rst_busy0",  busy0, 0);
    rst = 1'b0;
    step();

    // Plain packet, one byte per cycle, 1-cycle latency
    start = cyc; ps = rd1; nacc1 = 0;
    push1(8'h01, 0); push1(8'h02, 0); push1(8'h03, 1);
    exp1.push_back(8'hC0); exp1.push_back(8'h01); exp1.push_back(8'h02);
    exp1.push_back(8'h03); exp1.push_back(8'hC0);
    drain1(30, 0);
    check("t1_latency", first1 - start, 1);
    check("t1_span", lastc1 - first1, 4);
    check("t1_pops", rd1 - ps, 3);
    check("t1_idle_busy", busy1, 0);

    // Both reserved bytes escaped, pairs contiguous
    ps = rd1; nacc1 = 0;
    push1(8'hC0, 0); push1(8'hDB, 1);
    exp1.push_back(8'hC0); exp1.push_back(8'hDB); exp1.push_back(8'hDC);
    exp1.push_back(8'hDB); exp1.push_back(8'hDD); exp1.push_back(8'hC0);
    drain1(30, 0);
    check("t2_span", lastc1 - first1, 5);
    check("t2_pops", rd1 - ps, 2);

    // Backpressure toggling every cycle
    ps = rd1; nacc1 = 0;
    push1(8'h55, 0); push1(8'hAA, 1);
    exp1.push_back(8'hC0); exp1.push_back(8'h55); exp1.push_back(8'hAA);
    exp1.push_back(8'hC0);
    drain1(40, 1);
    check("t3_count", nacc1, 4);
    check("t3_pops", rd1 - ps, 2);

    // Back-to-back packets without leading END
    start = cyc; ps = rd0; nacc0 = 0; blow0 = 0;
    push0(8'h11, 1); push0(8'h22, 1);
    exp0.push_back(8'h11); exp0.push_back(8'hC0);
    exp0.push_back(8'h22); exp0.push_back(8'hC0);
    drain0(30);
    check("t4_latency", first0 - start, 1);
    check("t4_span", lastc0 - first0, 3);
    check("t4_busy_gap", blow0 <= 1, 1);
    check("t4_pops", rd0 - ps, 2);

    // Source empties mid-packet for 5 cycles
    ps = rd1; nacc1 = 0;
    push1(8'h01, 0); push1(8'h02, 1);
    exp1.push_back(8'hC0); exp1.push_back(8'h01); exp1.push_back(8'h02);
    exp1.push_back(8'hC0);
    n = 0;
    while (rd1 == ps && n < 10) begin step(); n++; end
    check("t5_first_pop", rd1 - ps, 1);
    hold1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_gap_ren", in_ren1, 0);
      check("t5_gap_valid", out_valid1, 0);
      check("t5_gap_busy", busy1, 1);
    end
    hold1 = 1'b0;
    drain1(30, 0);
    check("t5_pops", rd1 - ps, 2);

    // Asynchronous reset while in ESC2
    push1(8'hDB, 0); push1(8'h05, 1);
    exp1.push_back(8'hC0); exp1.push_back(8'hDB);
    n = 0;
    while (!(out_valid1 && out_data1 == 8'hDB) && n < 10) begin step(); n++; end
    check("t6_reach_esc2", dut1.state, ESC2);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", out_valid1, 0);
    check("t6_rst_state", dut1.state, IDLE);
    check("t6_rst_busy", busy1, 0);
    check("t6_rst_ren", in_ren1, 0);
    exp1.delete();
    step();
    rst = 1'b0;
    step();

    // Encoding resumes normally after reset
    ps = rd1; nacc1 = 0;
    push1(8'hC0, 1);
    exp1.push_back(8'hC0); exp1.push_back(8'hDB); exp1.push_back(8'hDC);
    exp1.push_back(8'hC0);
    drain1(30, 0);
    check("t7_count", nacc1, 4);
    check("t7_pops", rd1 - ps, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
